// File: rtl/mult_error_monitor.sv
// Error-statistics monitor for paired exact/approximate multiplier products.
// Optional signed bias accumulator enabled by defining SIGNED_BIAS_EN.
module mult_error_monitor #(
  parameter int Bitwidth = 8,
  parameter int SAMPLE_W = 17,
  parameter int ACC_W    = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SAMPLE_W-1:0]   num_samples,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*Bitwidth-1:0] exact_res,
  input  logic [2*Bitwidth-1:0] approx_res,
  output logic                  busy,
  output logic                  done,
  output logic [SAMPLE_W-1:0]   sample_cnt,
  output logic [SAMPLE_W-1:0]   err_cnt,
  output logic [ACC_W-1:0]      sum_ed,
  output logic [2*Bitwidth-1:0] max_ed
`ifdef SIGNED_BIAS_EN
  ,output logic signed [ACC_W-1:0] bias_sum
`endif
);

  localparam int W2 = 2 * Bitwidth;
  localparam logic [SAMPLE_W-1:0] ONE = {{(SAMPLE_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [W2-1:0] abs_diff(input logic [W2-1:0] a, input logic [W2-1:0] b);
    logic [W2:0] d;
    d = {1'b0, a} - {1'b0, b};
    d = d[W2] ? ({(W2+1){1'b0}} - d) : d;
    return d[W2-1:0];
  endfunction

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc, input logic [W2-1:0] inc);
    logic [ACC_W:0] s;
    s = {1'b0, acc} + {{(ACC_W+1-W2){1'b0}}, inc};
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  state_t              state_q, state_d;
  logic [SAMPLE_W-1:0] len_q, len_d;
  logic [SAMPLE_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [SAMPLE_W-1:0] err_cnt_q, err_cnt_d;
  logic [ACC_W-1:0]    sum_ed_q, sum_ed_d;
  logic [W2-1:0]       max_ed_q, max_ed_d;
  logic                s1_valid_q, s1_valid_d;
  logic [W2-1:0]       s1_ed_q, s1_ed_d;
  logic                s1_mis_q, s1_mis_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                xfer_s;

`ifdef SIGNED_BIAS_EN
  // Two's-complement add of a (W2+1)-bit difference, clamped at both signed limits.
  function automatic logic [ACC_W-1:0] sat_add_s(input logic [ACC_W-1:0] acc, input logic [W2:0] inc);
    logic [ACC_W:0] s;
    s = {acc[ACC_W-1], acc} + {{(ACC_W-W2){inc[W2]}}, inc};
    if (s[ACC_W] != s[ACC_W-1]) begin
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
    return s[ACC_W-1:0];
  endfunction

  logic [W2:0]      s1_bias_q, s1_bias_d;
  logic [ACC_W-1:0] bias_q, bias_d;
`endif

  assign xfer_s = in_valid & in_ready_q;

  // Next-state, pipeline and statistics update logic.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    sample_cnt_d = sample_cnt_q;
    err_cnt_d    = err_cnt_q;
    sum_ed_d     = sum_ed_q;
    max_ed_d     = max_ed_q;
    s1_valid_d   = xfer_s;
    s1_ed_d      = s1_ed_q;
    s1_mis_d     = s1_mis_q;
`ifdef SIGNED_BIAS_EN
    s1_bias_d    = s1_bias_q;
    bias_d       = bias_q;
`endif

    if (xfer_s) begin
      s1_ed_d  = abs_diff(exact_res, approx_res);
      s1_mis_d = (exact_res != approx_res);
`ifdef SIGNED_BIAS_EN
      s1_bias_d = {1'b0, approx_res} - {1'b0, exact_res};
`endif
    end else begin
      s1_ed_d = s1_ed_q;
    end

    if (s1_valid_q) begin
      err_cnt_d = err_cnt_q + {{(SAMPLE_W-1){1'b0}}, s1_mis_q};
      sum_ed_d  = sat_add(sum_ed_q, s1_ed_q);
      max_ed_d  = (s1_ed_q > max_ed_q) ? s1_ed_q : max_ed_q;
`ifdef SIGNED_BIAS_EN
      bias_d    = sat_add_s(bias_q, s1_bias_q);
`endif
    end else begin
      max_ed_d = max_ed_q;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_RUN;
          len_d        = (num_samples == {SAMPLE_W{1'b0}}) ? ONE : num_samples;
          sample_cnt_d = {SAMPLE_W{1'b0}};
          err_cnt_d    = {SAMPLE_W{1'b0}};
          sum_ed_d     = {ACC_W{1'b0}};
          max_ed_d     = {W2{1'b0}};
          s1_valid_d   = 1'b0;
`ifdef SIGNED_BIAS_EN
          bias_d       = {ACC_W{1'b0}};
`endif
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        if (xfer_s) begin
          sample_cnt_d = sample_cnt_q + ONE;
          state_d      = (sample_cnt_d == len_q) ? S_DRAIN : S_RUN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_RUN) && (sample_cnt_d < len_d);
    busy_d     = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d     = (state_d == S_DONE);
  end

  // State, pipeline and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      len_q        <= {SAMPLE_W{1'b0}};
      sample_cnt_q <= {SAMPLE_W{1'b0}};
      err_cnt_q    <= {SAMPLE_W{1'b0}};
      sum_ed_q     <= {ACC_W{1'b0}};
      max_ed_q     <= {W2{1'b0}};
      s1_valid_q   <= 1'b0;
      s1_ed_q      <= {W2{1'b0}};
      s1_mis_q     <= 1'b0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef SIGNED_BIAS_EN
      s1_bias_q    <= {(W2+1){1'b0}};
      bias_q       <= {ACC_W{1'b0}};
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
      sum_ed_q     <= sum_ed_d;
      max_ed_q     <= max_ed_d;
      s1_valid_q   <= s1_valid_d;
      s1_ed_q      <= s1_ed_d;
      s1_mis_q     <= s1_mis_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef SIGNED_BIAS_EN
      s1_bias_q    <= s1_bias_d;
      bias_q       <= bias_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sample_cnt = sample_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign sum_ed     = sum_ed_q;
  assign max_ed     = max_ed_q;
`ifdef SIGNED_BIAS_EN
  assign bias_sum   = $signed(bias_q);
`endif

endmodule

// File: tb/tb_mult_error_monitor.sv
// Scoreboarded random/directed bench for mult_error_monitor (ACC_W=17 to reach saturation).
module tb_mult_error_monitor;

  localparam int BW = 8;
  localparam int SW = 17;
  localparam int AW = 17;
  localparam int PW = 2 * BW;

  logic          clk = 1'b0;
  logic          rst, start, in_valid;
  logic [SW-1:0] num_samples;
  logic          in_ready, busy, done;
  logic [PW-1:0] exact_res, approx_res, max_ed;
  logic [SW-1:0] sample_cnt, err_cnt;
  logic [AW-1:0] sum_ed;
`ifdef SIGNED_BIAS_EN
  logic signed [AW-1:0] bias_sum;
`endif

  always #5 clk = ~clk;

  mult_error_monitor #(.Bitwidth(BW), .SAMPLE_W(SW), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready),
    .exact_res(exact_res), .approx_res(approx_res),
    .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .sum_ed(sum_ed), .max_ed(max_ed)
`ifdef SIGNED_BIAS_EN
    , .bias_sum(bias_sum)
`endif
  );

  typedef struct {
    longint cnt;
    longint err;
    longint sum;
    longint mx;
    longint bias;
  } exp_t;

  exp_t sb_q[$];
  int   ex_a[16];
  int   ap_a[16];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   done_prev = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference: statistics from the definition, saturating step by step.
  function automatic exp_t model(input int len);
    exp_t   e;
    longint d;
    longint umax = (64'sd1 <<< AW) - 1;
    longint smax = (64'sd1 <<< (AW - 1)) - 1;
    longint smin = -(64'sd1 <<< (AW - 1));
    e.cnt = len; e.err = 0; e.sum = 0; e.mx = 0; e.bias = 0;
    for (int i = 0; i < len; i++) begin
      d = longint'(ex_a[i]) - longint'(ap_a[i]);
      if (d != 0) e.err++;
      if (d < 0) d = -d;
      e.sum = e.sum + d;
      if (e.sum > umax) e.sum = umax;
      if (d > e.mx) e.mx = d;
      e.bias = e.bias + (longint'(ap_a[i]) - longint'(ex_a[i]));
      if (e.bias > smax) e.bias = smax;
      if (e.bias < smin) e.bias = smin;
    end
    return e;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_sample_cnt"}, sample_cnt, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_sum_ed"}, sum_ed, 0);
    check({tag, "_max_ed"}, max_ed, 0);
`ifdef SIGNED_BIAS_EN
    check({tag, "_bias_sum"}, bias_sum, 0);
`endif
  endtask

  // Runs one window over ex_a/ap_a; expected result goes to the scoreboard up front.
  task automatic run_window(input int len_in, input bit gaps, input bit poke_start);
    int L = (len_in == 0) ? 1 : len_in;
    int idx = 0;
    int cyc = 0;
    bit v;
    sb_q.push_back(model(L));
    start = 1'b1;
    num_samples = SW'(len_in);
    @(posedge clk); #1;
    start = 1'b0;
    check("run_entry_busy", busy, 1);
    while (idx < L && cyc < 500) begin
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_valid = v;
      exact_res = PW'(ex_a[idx]);
      approx_res = PW'(ap_a[idx]);
      if (poke_start && $urandom_range(0, 3) == 0) begin
        start = 1'b1;
        num_samples = SW'($urandom_range(0, 20));
      end
      check("in_ready_run", in_ready, 1);
      @(posedge clk); #1;
      start = 1'b0;
      if (v) idx++;
      cyc++;
    end
    if (idx < L) begin
      n_checks++;
      n_fail++;
      $display("FAIL window_timeout: got %0d transfers, required %0d", idx, L);
    end
    in_valid = 1'b1;
    exact_res = 16'd1234;
    approx_res = 16'd4321;
    check("drain_in_ready", in_ready, 0);
    check("drain_busy", busy, 1);
    check("drain_done", done, 0);
    check("drain_sample_cnt", sample_cnt, L);
    @(posedge clk); #1;
    check("done_rise", done, 1);
    check("done_busy", busy, 0);
    check("done_in_ready", in_ready, 0);
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("done_hold", done, 1);
    check("hold_sample_cnt", sample_cnt, L);
  endtask

  // Monitor: compares statistics against the scoreboard on every rising edge of done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done && !done_prev) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done with empty scoreboard, required none");
        end else begin
          e = sb_q.pop_front();
          check("sb_sample_cnt", sample_cnt, e.cnt);
          check("sb_err_cnt", err_cnt, e.err);
          check("sb_sum_ed", sum_ed, e.sum);
          check("sb_max_ed", max_ed, e.mx);
`ifdef SIGNED_BIAS_EN
          check("sb_bias_sum", bias_sum, e.bias);
`endif
        end
      end
      done_prev = done;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int len;
    int mode;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; num_samples = '0;
    exact_res = '0; approx_res = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    in_valid = 1'b1;
    exact_res = 16'd500;
    approx_res = 16'd3;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check_all_zero("idle_valid");
    in_valid = 1'b0;

    ex_a[0:3] = '{0, 255, 1000, 65025};
    ap_a[0:3] = '{0, 255, 1000, 65025};
    run_window(4, 1'b0, 1'b0);

    ex_a[0:2] = '{100, 50, 7};
    ap_a[0:2] = '{96, 58, 7};
    run_window(3, 1'b0, 1'b0);

    ex_a[0:1] = '{300, 20};
    ap_a[0:1] = '{310, 20};
    run_window(2, 1'b1, 1'b0);

    for (int i = 0; i < 4; i++) begin
      ex_a[i] = 65535;
      ap_a[i] = 0;
    end
    run_window(4, 1'b0, 1'b0);

    // Abort a window after one transfer, then restart with length 0.
    ex_a[0] = 9; ap_a[0] = 2;
    start = 1'b1; num_samples = 17'd5;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1; exact_res = 16'd900; approx_res = 16'd100;
    check("abort_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_all_zero("abort");
    @(posedge clk); #1;
    check_all_zero("abort_settle");
    ex_a[0] = 10; ap_a[0] = 3;
    run_window(0, 1'b0, 1'b0);

    for (int w = 0; w < 25; w++) begin
      len = $urandom_range(0, 12);
      mode = $urandom_range(0, 2);
      for (int i = 0; i < 16; i++) begin
        ex_a[i] = $urandom_range(0, 65535);
        case (mode)
          0: ap_a[i] = ($urandom_range(0, 1) == 0) ? ex_a[i] : $urandom_range(0, 65535);
          1: ap_a[i] = (ex_a[i] > 300) ? ex_a[i] - $urandom_range(0, 300) : ex_a[i] + $urandom_range(0, 300);
          default: ap_a[i] = $urandom_range(0, 65535);
        endcase
      end
      run_window(len, 1'b1, 1'b1);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
